cache_buffer_responder: RTL and testbench

Memory-side responder for the cache-to-internal-memory-controller request interface. Accepts word and block requests from a cache controller, and collects write data through a write handshake into a single block buffer. Serves read/fill data back through a read handshake. Translates each request into per-word transactions on a simple backing-memory port, and sits between a cache instance and the external memory system.

---
 rtl/cache_buffer_responder.sv | 194 +++++++++++++++++++
 tb/tb_cache_buffer_responder.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_buffer_responder.sv
// Memory-side responder: accepts word/block requests from a cache, buffers one
// block of data and translates each request into per-word backing-memory transactions.
module cache_buffer_responder #(
  parameter int unsigned BW_ADDR  = 24,
  parameter int unsigned BW_BLOCK = 4
) (
  input  logic               clock_i,
  input  logic               reset_i,
  output logic               en_o,
  input  logic               req_i,
  input  logic               req_block_i,
  input  logic               rw_i,
  input  logic [BW_ADDR-1:0] add_i,
  output logic               ready_req_o,
  input  logic               write_i,
  input  logic [31:0]        data_i,
  output logic               ready_write_o,
  input  logic               read_i,
  output logic               ready_read_o,
  output logic [31:0]        data_o,
  output logic               mem_req_o,
  output logic               mem_rw_o,
  output logic [BW_ADDR-1:0] mem_addr_o,
  output logic [31:0]        mem_data_o,
  input  logic               mem_ready_i,
  input  logic               mem_valid_i,
  input  logic [31:0]        mem_data_i
);

  localparam int unsigned N  = 1 << BW_BLOCK;
  localparam int unsigned CW = BW_BLOCK + 1;

  typedef enum logic [1:0] {IDLE, WR_COLLECT, WR_ISSUE, RD_ACTIVE} state_t;

  state_t               state_q, state_d;
  logic                 en_q, en_d;
  logic                 ready_req_q, ready_req_d;
  logic                 ready_write_q, ready_write_d;
  logic                 ready_read_q, ready_read_d;
  logic [31:0]          data_q, data_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_rw_q, mem_rw_d;
  logic [BW_ADDR-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]          mem_data_q, mem_data_d;
  logic                 blk_q, blk_d;
  logic [CW-1:0]        len_q, len_d;
  logic [BW_ADDR-1:0]   base_q, base_d;
  logic [CW-1:0]        pushed_q, pushed_d;
  logic [CW-1:0]        issued_q, issued_d;
  logic [CW-1:0]        received_q, received_d;
  logic [CW-1:0]        count_q, count_d;
  logic [BW_BLOCK-1:0]  rd_ptr_q, rd_ptr_d;
  logic [BW_BLOCK-1:0]  wr_ptr_q, wr_ptr_d;

  logic                 push, pop;
  logic [31:0]          push_data, head;
  logic [BW_ADDR-1:0]   addr_next;
  logic [31:0]          buf_q [N];

  // Next-state, buffer bookkeeping and registered-output computation.
  always_comb begin
    state_d    = state_q;
    en_d       = 1'b1;
    blk_d      = blk_q;
    len_d      = len_q;
    base_d     = base_q;
    pushed_d   = pushed_q;
    issued_d   = issued_q;
    received_d = received_q;
    push       = 1'b0;
    pop        = 1'b0;
    push_data  = data_i;

    case (state_q)
      IDLE: begin
        if (req_i && ready_req_q) begin
          blk_d      = req_block_i;
          len_d      = req_block_i ? CW'(N) : CW'(1);
          base_d     = req_block_i ? {add_i[BW_ADDR-1:BW_BLOCK], {BW_BLOCK{1'b0}}} : add_i;
          pushed_d   = '0;
          issued_d   = '0;
          received_d = '0;
          state_d    = rw_i ? WR_COLLECT : RD_ACTIVE;
        end
      end
      WR_COLLECT: begin
        if (write_i && ready_write_q) begin
          push     = 1'b1;
          pushed_d = pushed_q + CW'(1);
          if (pushed_d == len_q) state_d = WR_ISSUE;
        end
      end
      WR_ISSUE: begin
        if (mem_req_q && mem_ready_i) begin
          pop      = 1'b1;
          issued_d = issued_q + CW'(1);
          if (issued_d == len_q) state_d = IDLE;
        end
      end
      RD_ACTIVE: begin
        if (mem_req_q && mem_ready_i) issued_d = issued_q + CW'(1);
        if (mem_valid_i && (received_q < len_q)) begin
          push       = 1'b1;
          push_data  = mem_data_i;
          received_d = received_q + CW'(1);
        end
        if (read_i && ready_read_q) pop = 1'b1;
        if ((received_q == len_q) && (count_q == '0) && !push && !pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + BW_BLOCK'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + BW_BLOCK'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A word written this edge into the slot that becomes head must be forwarded.
    head      = (push && (wr_ptr_q == rd_ptr_d)) ? push_data : buf_q[rd_ptr_d];
    addr_next = blk_d ? {base_d[BW_ADDR-1:BW_BLOCK], issued_d[BW_BLOCK-1:0]} : base_d;

    ready_req_d   = en_d && (state_d == IDLE);
    ready_write_d = (state_d == WR_COLLECT) && (pushed_d < len_d);
    ready_read_d  = (state_d == RD_ACTIVE) && (count_d != '0);
    mem_req_d     = ((state_d == WR_ISSUE) || (state_d == RD_ACTIVE)) && (issued_d < len_d);
    mem_rw_d      = mem_req_d ? (state_d == WR_ISSUE) : mem_rw_q;
    mem_addr_d    = mem_req_d ? addr_next : mem_addr_q;
    data_d        = (count_d != '0) ? head : data_q;
    mem_data_d    = ((state_d == WR_ISSUE) && (count_d != '0)) ? head : mem_data_q;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      en_q          <= 1'b0;
      ready_req_q   <= 1'b0;
      ready_write_q <= 1'b0;
      ready_read_q  <= 1'b0;
      data_q        <= '0;
      mem_req_q     <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      blk_q         <= 1'b0;
      len_q         <= '0;
      base_q        <= '0;
      pushed_q      <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      ready_req_q   <= ready_req_d;
      ready_write_q <= ready_write_d;
      ready_read_q  <= ready_read_d;
      data_q        <= data_d;
      mem_req_q     <= mem_req_d;
      mem_rw_q      <= mem_rw_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      blk_q         <= blk_d;
      len_q         <= len_d;
      base_q        <= base_d;
      pushed_q      <= pushed_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Buffer storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clock_i) begin
    if (push) buf_q[wr_ptr_q] <= push_data;
  end

  assign en_o          = en_q;
  assign ready_req_o   = ready_req_q;
  assign ready_write_o = ready_write_q;
  assign ready_read_o  = ready_read_q;
  assign data_o        = data_q;
  assign mem_req_o     = mem_req_q;
  assign mem_rw_o      = mem_rw_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_data_o    = mem_data_q;

endmodule

// File: tb/tb_cache_buffer_responder.sv
// Scoreboard bench for cache_buffer_responder: a request-level model predicts memory
// transactions and cache read data; monitors compare whenever the DUT hands something over.
module tb_cache_buffer_responder;

  localparam int unsigned BW_ADDR  = 24;
  localparam int unsigned BW_BLOCK = 4;
  localparam int unsigned N        = 16;

  logic               clock_i, reset_i, en_o;
  logic               req_i, req_block_i, rw_i;
  logic [BW_ADDR-1:0] add_i;
  logic               ready_req_o, write_i, ready_write_o, read_i, ready_read_o;
  logic [31:0]        data_i, data_o;
  logic               mem_req_o, mem_rw_o, mem_ready_i, mem_valid_i;
  logic [BW_ADDR-1:0] mem_addr_o;
  logic [31:0]        mem_data_o, mem_data_i;

  cache_buffer_responder #(.BW_ADDR(BW_ADDR), .BW_BLOCK(BW_BLOCK)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .en_o(en_o),
    .req_i(req_i), .req_block_i(req_block_i), .rw_i(rw_i), .add_i(add_i),
    .ready_req_o(ready_req_o), .write_i(write_i), .data_i(data_i),
    .ready_write_o(ready_write_o), .read_i(read_i), .ready_read_o(ready_read_o),
    .data_o(data_o), .mem_req_o(mem_req_o), .mem_rw_o(mem_rw_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i)
  );

  typedef struct packed {
    logic        rw;
    logic [23:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  mem_txn_t    exp_mem[$];
  logic [31:0] exp_rd[$];
  logic [31:0] ret_q[$];
  logic [31:0] wbuf [16];
  int          total = 0;
  int          bad   = 0;
  int          rdy_mode = 2;
  bit          ret_fast = 1'b1;
  bit          read_en  = 1'b0;
  bit          stray_valid = 1'b0;
  int          rcv_cnt = 0;
  logic [31:0] last_rd = 32'h0;
  logic [23:0] last_addr = 24'h0;

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    return {8'h00, a};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  task automatic flush();
    exp_mem.delete();
    exp_rd.delete();
    ret_q.delete();
  endtask

  // Request-level model: word k of a block lives at aligned base + k.
  task automatic model_req(input bit rw, input bit blk, input logic [23:0] a);
    int unsigned au   = 32'(a);
    int unsigned len  = blk ? N : 1;
    int unsigned base = blk ? (au / N) * N : au;
    mem_txn_t    t;
    for (int unsigned k = 0; k < len; k++) begin
      t.rw   = rw;
      t.addr = 24'(base + k);
      t.data = rw ? wbuf[k] : 32'h0;
      exp_mem.push_back(t);
      if (!rw) exp_rd.push_back(mem_word(t.addr));
      last_addr = t.addr;
    end
  endtask

  task automatic issue(input bit rw, input bit blk, input logic [23:0] a);
    int g = 0;
    @(negedge clock_i);
    while (!ready_req_o && g < 2000) begin
      @(negedge clock_i);
      g++;
    end
    check("req_ready_wait", 32'(ready_req_o), 32'd1);
    model_req(rw, blk, a);
    @(posedge clock_i); #1;
    req_i = 1'b1; rw_i = rw; req_block_i = blk; add_i = a;
    @(posedge clock_i); #1;
    req_i = 1'b0;
    check("req_ready_drop", 32'(ready_req_o), 32'd0);
  endtask

  task automatic push_writes(input int len);
    int idx = 0;
    int g = 0;
    while (idx < len && g < 1000) begin
      write_i = ($urandom_range(0, 3) != 0);
      data_i  = wbuf[idx];
      @(negedge clock_i);
      if (write_i && ready_write_o) idx++;
      @(posedge clock_i); #1;
      g++;
    end
    check("wr_pushed", 32'(idx), 32'(len));
    write_i = 1'b1;
    data_i  = 32'hDEAD_BEEF;
    @(negedge clock_i);
    check("wr_ready_drop", 32'(ready_write_o), 32'd0);
    @(posedge clock_i); #1;
    write_i = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    @(negedge clock_i);
    while (!(exp_mem.size() == 0 && exp_rd.size() == 0 && ready_req_o) && g < 3000) begin
      @(negedge clock_i);
      g++;
    end
    check("idle_reached", 32'(g < 3000), 32'd1);
    if (g >= 3000) flush();
  endtask

  // Backing memory: ready policy plus in-order read returns.
  initial begin
    mem_ready_i = 1'b0;
    mem_valid_i = 1'b0;
    mem_data_i  = 32'h0;
    forever begin
      @(posedge clock_i); #1;
      if (reset_i) begin
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b0;
      end else begin
        case (rdy_mode)
          0:       mem_ready_i = ($urandom_range(0, 1) == 1);
          1:       mem_ready_i = ~mem_ready_i;
          2:       mem_ready_i = 1'b1;
          default: mem_ready_i = 1'b0;
        endcase
        if (stray_valid) begin
          mem_valid_i = 1'b1;
          mem_data_i  = 32'hBAD0_BAD0;
        end else if (ret_q.size() > 0 && (ret_fast || $urandom_range(0, 2) != 0)) begin
          mem_valid_i = 1'b1;
          mem_data_i  = ret_q.pop_front();
          rcv_cnt++;
        end else begin
          mem_valid_i = 1'b0;
        end
      end
    end
  end

  initial begin
    read_i = 1'b0;
    forever begin
      @(posedge clock_i); #1;
      read_i = read_en && !reset_i && ($urandom_range(0, 1) == 1);
    end
  end

  // Memory-side monitor: scoreboard of transactions and stall stability.
  initial begin
    mem_txn_t    e;
    bit          prev_stall = 1'b0;
    logic [23:0] prev_addr  = 24'h0;
    logic [31:0] prev_data  = 32'h0;
    logic        prev_rw    = 1'b0;
    forever begin
      @(negedge clock_i);
      if (reset_i) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("mem_hold_req", 32'(mem_req_o), 32'd1);
          check("mem_hold_addr", 32'(mem_addr_o), 32'(prev_addr));
          if (prev_rw) check("mem_hold_data", mem_data_o, prev_data);
        end
        if (mem_req_o && mem_ready_i) begin
          if (exp_mem.size() == 0) begin
            check("mem_unexpected", 32'(mem_addr_o), 32'hFFFF_FFFF);
          end else begin
            e = exp_mem.pop_front();
            check("mem_rw", 32'(mem_rw_o), 32'(e.rw));
            check("mem_addr", 32'(mem_addr_o), 32'(e.addr));
            if (e.rw) check("mem_wdata", mem_data_o, e.data);
          end
          if (!mem_rw_o) ret_q.push_back(mem_word(mem_addr_o));
        end
        prev_stall = mem_req_o && !mem_ready_i;
        prev_addr  = mem_addr_o;
        prev_data  = mem_data_o;
        prev_rw    = mem_rw_o;
      end
    end
  end

  // Cache-side monitor: every accepted pop must deliver the next predicted word.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock_i);
      if (!reset_i && read_i && ready_read_o) begin
        if (exp_rd.size() == 0) begin
          check("rd_unexpected", data_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_rd.pop_front();
          check("rd_data", data_o, e);
          last_rd = e;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    reset_i = 1'b1;
    req_i = 1'b0; req_block_i = 1'b0; rw_i = 1'b0; add_i = '0;
    write_i = 1'b0; data_i = 32'h0;

    #12;
    check("rst_en", 32'(en_o), 32'd0);
    check("rst_ready_req", 32'(ready_req_o), 32'd0);
    check("rst_ready_write", 32'(ready_write_o), 32'd0);
    check("rst_ready_read", 32'(ready_read_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_rw", 32'(mem_rw_o), 32'd0);
    check("rst_data", data_o, 32'h0);
    check("rst_mem_addr", 32'(mem_addr_o), 32'h0);
    check("rst_mem_data", mem_data_o, 32'h0);
    @(negedge clock_i);
    reset_i = 1'b0;
    #1;
    check("en_before_edge", 32'(en_o), 32'd0);
    @(posedge clock_i); #1;
    check("en_after_edge", 32'(en_o), 32'd1);
    check("ready_req_after_edge", 32'(ready_req_o), 32'd1);

    // Word read with single-cycle memory: exact latency to the cache.
    rdy_mode = 2; ret_fast = 1'b1; read_en = 1'b0;
    issue(1'b0, 1'b0, 24'h001235);
    @(negedge clock_i);
    check("wrd_mem_req", 32'(mem_req_o), 32'd1);
    check("wrd_mem_addr", 32'(mem_addr_o), 32'h001235);
    check("wrd_not_ready_t0", 32'(ready_read_o), 32'd0);
    @(negedge clock_i);
    check("wrd_not_ready_t1", 32'(ready_read_o), 32'd0);
    @(negedge clock_i);
    check("wrd_ready_t2", 32'(ready_read_o), 32'd1);
    check("wrd_data", data_o, 32'h0000_1235);
    read_en = 1'b1;
    wait_idle();
    check("wrd_idle_ready", 32'(ready_req_o), 32'd1);

    // Block read with random memory timing and random cache pops.
    rdy_mode = 0; ret_fast = 1'b0; read_en = 1'b1;
    issue(1'b0, 1'b1, 24'h00123A);
    wait_idle();

    // Block write with memory ready toggling every other cycle.
    for (int k = 0; k < 16; k++) wbuf[k] = 32'(32'hA0 + k);
    rdy_mode = 1;
    issue(1'b1, 1'b1, 24'h000040);
    push_writes(16);
    wait_idle();

    // Illegal stimulus while a read is stalled, then a stray return in IDLE.
    rdy_mode = 3; read_en = 1'b1;
    issue(1'b0, 1'b0, 24'h000777);
    for (int c = 0; c < 3; c++) begin
      req_i = 1'b1; rw_i = 1'b1; req_block_i = 1'b1; add_i = 24'h123456;
      @(negedge clock_i);
      check("ill_ready_req", 32'(ready_req_o), 32'd0);
      check("ill_mem_req", 32'(mem_req_o), 32'd1);
      check("ill_mem_addr", 32'(mem_addr_o), 32'h000777);
      check("ill_ready_read", 32'(ready_read_o), 32'd0);
      @(posedge clock_i); #1;
    end
    req_i = 1'b0;
    rdy_mode = 2; ret_fast = 1'b1;
    wait_idle();
    stray_valid = 1'b1;
    @(posedge clock_i); #2;
    stray_valid = 1'b0;
    @(negedge clock_i);
    @(negedge clock_i);
    check("stray_ready_read", 32'(ready_read_o), 32'd0);
    check("stray_data", data_o, last_rd);
    check("stray_mem_addr", 32'(mem_addr_o), 32'(last_addr));
    check("stray_ready_req", 32'(ready_req_o), 32'd1);

    // Reset in the middle of a block read after five words have arrived.
    rdy_mode = 2; ret_fast = 1'b1; read_en = 1'b0; rcv_cnt = 0;
    issue(1'b0, 1'b1, 24'h000500);
    g = 0;
    while (rcv_cnt < 5 && g < 200) begin
      @(negedge clock_i);
      g++;
    end
    check("mid_rst_rcv5", 32'(rcv_cnt >= 5), 32'd1);
    @(posedge clock_i); #2;
    reset_i = 1'b1;
    #1;
    check("mid_rst_en", 32'(en_o), 32'd0);
    check("mid_rst_ready_req", 32'(ready_req_o), 32'd0);
    check("mid_rst_ready_read", 32'(ready_read_o), 32'd0);
    check("mid_rst_mem_req", 32'(mem_req_o), 32'd0);
    check("mid_rst_data", data_o, 32'h0);
    check("mid_rst_mem_addr", 32'(mem_addr_o), 32'h0);
    flush();
    @(posedge clock_i);
    @(posedge clock_i);
    flush();
    @(negedge clock_i);
    reset_i = 1'b0;
    flush();
    @(posedge clock_i); #1;
    check("post_rst_en", 32'(en_o), 32'd1);
    check("post_rst_ready_req", 32'(ready_req_o), 32'd1);
    read_en = 1'b1;
    issue(1'b0, 1'b0, 24'h00ABCD);
    wait_idle();

    // Randomised mix of requests and memory timings.
    for (int i = 0; i < 24; i++) begin
      bit          rw, blk;
      logic [23:0] a;
      rw  = ($urandom_range(0, 1) == 1);
      blk = ($urandom_range(0, 1) == 1);
      a   = 24'($urandom);
      rdy_mode = $urandom_range(0, 2);
      ret_fast = ($urandom_range(0, 1) == 1);
      read_en  = 1'b1;
      for (int k = 0; k < 16; k++) wbuf[k] = $urandom;
      issue(rw, blk, a);
      if (rw) push_writes(blk ? 16 : 1);
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
